// File: rtl/multicycle_ctrl_hs_pkg.sv
// Shared types and encodings for the multicycle MIPS-style controller:
// state enum, opcode constants, datapath select encodings and the output bundle.
package multicycle_ctrl_hs_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRCB_REG    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       branch_ne;
        logic       illegal;
        logic       fault;
    } ctrl_t;

    // States that hold a memory request open and therefore count wait cycles.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_hs_if.sv
// Controller <-> datapath/memory bundle. The controller is the master; funct and
// zero belong to the datapath side (ALU decoder, branch PC enable) only.
interface multicycle_ctrl_hs_if;
    import multicycle_ctrl_hs_pkg::*;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       branch_ne;
    logic       illegal;
    logic       fault;

    modport master (
        input  op, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcwrite, pcwritecond,
               regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop,
               branch_ne, illegal, fault
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcwrite, pcwritecond,
               regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop,
               branch_ne, illegal, fault
    );

endinterface

// File: rtl/multicycle_ctrl_hs_wait_timer.sv
// Memory wait-state counter: restarts on every state change, counts stalled
// cycles, and flags a timeout on the last tolerated stall.
module mc_wait_timer #(
    parameter int TIMEOUT_W = 4,
    parameter int MAX_WAIT  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    input  logic state_change,
    output logic timeout
);

    localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(MAX_WAIT - 1);

    logic [TIMEOUT_W-1:0] count_reg;
    logic [TIMEOUT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (state_change) begin
            count_next = '0;
        end else if (waiting && !mem_ready) begin
            count_next = count_reg + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // A ready in the final cycle still wins over the timeout.
    assign timeout = waiting && !mem_ready && (count_reg == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle controller FSM with memory handshake, wait-state timeout and
// illegal-opcode detection.
module multicycle_ctrl_hs
    import multicycle_ctrl_hs_pkg::*;
#(
    parameter int TIMEOUT_W = 4,
    parameter int MAX_WAIT  = 8,
    parameter bit HAS_BNE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_hs_if.master  bus
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;
    logic   waiting;
    logic   state_change;
    logic   timeout;

    assign waiting      = is_wait_state(state_reg);
    assign state_change = (state_next != state_reg);

    mc_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W),
        .MAX_WAIT  (MAX_WAIT)
    ) u_wait_timer (
        .clk          (clk),
        .reset        (reset),
        .waiting      (waiting),
        .mem_ready    (bus.mem_ready),
        .state_change (state_change),
        .timeout      (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ctrl       = '0;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = ALUSRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                if (bus.mem_ready) begin
                    ctrl.irwrite = 1'b1;
                    ctrl.pcwrite = 1'b1;
                    state_next   = S_DECODE;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                ctrl.alusrcb = ALUSRCB_IMM_SH;
                case (bus.op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_BNE: begin
                        if (HAS_BNE) begin
                            state_next = S_BRANCH;
                        end else begin
                            ctrl.illegal = 1'b1;
                            state_next   = S_FETCH;
                        end
                    end
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_next   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                state_next   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                // The write strobe fires only in the completing cycle.
                if (bus.mem_ready) begin
                    ctrl.memwrite = 1'b1;
                    state_next    = S_FETCH;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                state_next    = S_FETCH;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_REG;
                ctrl.aluop   = ALUOP_FUNCT;
                state_next   = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                state_next    = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                state_next   = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = ALUSRCB_REG;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcsrc       = PCSRC_ALUOUT;
                ctrl.pcwritecond = 1'b1;
                ctrl.branch_ne   = (bus.op == OP_BNE);
                state_next       = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
        // Reset sits the state in FETCH, so outputs are masked explicitly.
        if (reset) begin
            ctrl = '0;
        end
    end

    assign bus.mem_req     = ctrl.mem_req;
    assign bus.memwrite    = ctrl.memwrite;
    assign bus.iord        = ctrl.iord;
    assign bus.irwrite     = ctrl.irwrite;
    assign bus.pcwrite     = ctrl.pcwrite;
    assign bus.pcwritecond = ctrl.pcwritecond;
    assign bus.regwrite    = ctrl.regwrite;
    assign bus.regdst      = ctrl.regdst;
    assign bus.memtoreg    = ctrl.memtoreg;
    assign bus.alusrca     = ctrl.alusrca;
    assign bus.alusrcb     = ctrl.alusrcb;
    assign bus.pcsrc       = ctrl.pcsrc;
    assign bus.aluop       = ctrl.aluop;
    assign bus.branch_ne   = ctrl.branch_ne;
    assign bus.illegal     = ctrl.illegal;
    assign bus.fault       = ctrl.fault;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Directed bench for multicycle_ctrl_hs: two instances (BNE decoded / not decoded)
// share stimulus; every cycle's output bundle is compared with a hand-written vector.
module tb_multicycle_ctrl_hs;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_ctrl_hs_if bus0 ();
    multicycle_ctrl_hs_if bus1 ();

    assign bus0.op = op;  assign bus0.funct = funct;  assign bus0.zero = zero;  assign bus0.mem_ready = mem_ready;
    assign bus1.op = op;  assign bus1.funct = funct;  assign bus1.zero = zero;  assign bus1.mem_ready = mem_ready;

    multicycle_ctrl_hs #(.TIMEOUT_W(4), .MAX_WAIT(8), .HAS_BNE(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master)
    );
    multicycle_ctrl_hs #(.TIMEOUT_W(4), .MAX_WAIT(8), .HAS_BNE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.master)
    );

    // {mem_req,memwrite,iord,irwrite,pcwrite,pcwritecond,regwrite,regdst,memtoreg,alusrca,
    //  alusrcb[2],pcsrc[2],aluop[2],branch_ne,illegal,fault}
    logic [18:0] obs0;
    logic [18:0] obs1;
    assign obs0 = {bus0.mem_req, bus0.memwrite, bus0.iord, bus0.irwrite, bus0.pcwrite,
                   bus0.pcwritecond, bus0.regwrite, bus0.regdst, bus0.memtoreg, bus0.alusrca,
                   bus0.alusrcb, bus0.pcsrc, bus0.aluop, bus0.branch_ne, bus0.illegal, bus0.fault};
    assign obs1 = {bus1.mem_req, bus1.memwrite, bus1.iord, bus1.irwrite, bus1.pcwrite,
                   bus1.pcwritecond, bus1.regwrite, bus1.regdst, bus1.memtoreg, bus1.alusrca,
                   bus1.alusrcb, bus1.pcsrc, bus1.aluop, bus1.branch_ne, bus1.illegal, bus1.fault};

    localparam logic [18:0] E_IDLE       = '0;
    localparam logic [18:0] E_FETCH_WAIT = {10'b1000000000, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_FETCH_RDY  = {10'b1001100000, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_DECODE     = {10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_DECODE_ILL = {10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b010};
    localparam logic [18:0] E_MEMADR     = {10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_MEMACC     = {10'b1010000000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_MEMWR_RDY  = {10'b1110000000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_MEMWB      = {10'b0000001010, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_EXEC       = {10'b0000000001, 2'b00, 2'b00, 2'b10, 3'b000};
    localparam logic [18:0] E_ALUWB      = {10'b0000001100, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_ADDIWB     = {10'b0000001000, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [18:0] E_BEQ        = {10'b0000010001, 2'b00, 2'b01, 2'b01, 3'b000};
    localparam logic [18:0] E_BNE        = {10'b0000010001, 2'b00, 2'b01, 2'b01, 3'b100};
    localparam logic [18:0] E_JUMP       = {10'b0000100000, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [18:0] E_FAULT      = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b001};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            $display("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end else begin
            n_pass++;
        end
    endtask

    // Called at posedge+1: drive inputs, compare both instances at the negedge.
    task automatic step(input string tag, input logic [5:0] op_v, input logic mr_v,
                        input logic [18:0] exp0, input logic [18:0] exp1);
        op        = op_v;
        mem_ready = mr_v;
        @(negedge clk);
        $display("[%0t] %s op=%b mem_ready=%b out0=%h out1=%h", $time, tag, op_v, mr_v, obs0, obs1);
        check_value({tag, "/dut0"}, 32'(obs0), 32'(exp0));
        check_value({tag, "/dut1"}, 32'(obs1), 32'(exp1));
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input string tag, input logic [5:0] op_v, input logic mr_v, input logic [18:0] expv);
        step(tag, op_v, mr_v, expv, expv);
    endtask

    // Assert reset mid-cycle, check outputs clear immediately, release after the next edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        $display("[%0t] %s reset asserted out0=%h out1=%h", $time, tag, obs0, obs1);
        check_value({tag, "/dut0"}, 32'(obs0), 32'(E_IDLE));
        check_value({tag, "/dut1"}, 32'(obs1), 32'(E_IDLE));
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check_value("reset/dut0", 32'(obs0), 32'(E_IDLE));
        check_value("reset/dut1", 32'(obs1), 32'(E_IDLE));
        @(posedge clk);
        #1 reset = 1'b0;

        // lw, memory always ready: five cycles ending in a memory writeback
        step2("lw_fetch",  6'b100011, 1'b1, E_FETCH_RDY);
        step2("lw_decode", 6'b100011, 1'b1, E_DECODE);
        step2("lw_memadr", 6'b100011, 1'b1, E_MEMADR);
        step2("lw_memrd",  6'b100011, 1'b1, E_MEMACC);
        step2("lw_memwb",  6'b100011, 1'b1, E_MEMWB);

        // sw with three stalled cycles in MEMWR
        step2("sw_fetch",  6'b101011, 1'b1, E_FETCH_RDY);
        step2("sw_decode", 6'b101011, 1'b1, E_DECODE);
        step2("sw_memadr", 6'b101011, 1'b0, E_MEMADR);
        for (int i = 0; i < 3; i++) begin
            step2("sw_memwr_wait", 6'b101011, 1'b0, E_MEMWR_WAIT_F());
        end
        step2("sw_memwr_rdy", 6'b101011, 1'b1, E_MEMWR_RDY);
        step2("sw_back_fetch", 6'b101011, 1'b0, E_FETCH_WAIT);

        // R-type and addi
        step2("r_fetch",  6'b000000, 1'b1, E_FETCH_RDY);
        step2("r_decode", 6'b000000, 1'b0, E_DECODE);
        step2("r_exec",   6'b000000, 1'b0, E_EXEC);
        step2("r_aluwb",  6'b000000, 1'b0, E_ALUWB);
        step2("addi_fetch",  6'b001000, 1'b1, E_FETCH_RDY);
        step2("addi_decode", 6'b001000, 1'b0, E_DECODE);
        step2("addi_ex",     6'b001000, 1'b0, E_MEMADR);
        step2("addi_wb",     6'b001000, 1'b0, E_ADDIWB);

        // beq, then bne which only the HAS_BNE=1 instance decodes
        zero = 1'b1;
        step2("beq_fetch",  6'b000100, 1'b1, E_FETCH_RDY);
        step2("beq_decode", 6'b000100, 1'b0, E_DECODE);
        step2("beq_branch", 6'b000100, 1'b0, E_BEQ);
        zero = 1'b0;
        step2("bne_fetch",  6'b000101, 1'b1, E_FETCH_RDY);
        step("bne_decode",  6'b000101, 1'b0, E_DECODE, E_DECODE_ILL);
        step("bne_branch",  6'b000101, 1'b0, E_BNE, E_FETCH_WAIT);

        // undecoded opcode: one-cycle illegal pulse, then back to FETCH with no writes
        step2("ill_fetch",  6'b111111, 1'b1, E_FETCH_RDY);
        step2("ill_decode", 6'b111111, 1'b0, E_DECODE_ILL);
        step2("ill_refetch", 6'b111111, 1'b0, E_FETCH_WAIT);

        // jump, then a fetch that completes on the very last tolerated wait
        step2("j_fetch",  6'b000010, 1'b1, E_FETCH_RDY);
        step2("j_decode", 6'b000010, 1'b0, E_DECODE);
        step2("j_jump",   6'b000010, 1'b0, E_JUMP);
        for (int i = 0; i < 7; i++) begin
            step2("edge_fetch_wait", 6'b000010, 1'b0, E_FETCH_WAIT);
        end
        step2("edge_fetch_rdy", 6'b000010, 1'b1, E_FETCH_RDY);
        step2("edge_decode",    6'b000010, 1'b0, E_DECODE);
        step2("edge_jump",      6'b000010, 1'b0, E_JUMP);

        // eight stalled fetches -> FAULT, sticky even when memory becomes ready
        for (int i = 0; i < 8; i++) begin
            step2("to_fetch_wait", 6'b100011, 1'b0, E_FETCH_WAIT);
        end
        step2("fault_0", 6'b100011, 1'b1, E_FAULT);
        step2("fault_1", 6'b100011, 1'b0, E_FAULT);
        step2("fault_2", 6'b100011, 1'b1, E_FAULT);
        async_reset("fault_reset");
        step2("post_fault_fetch", 6'b100011, 1'b1, E_FETCH_RDY);

        // reset in the middle of a stalled lw read
        step2("rst_decode", 6'b100011, 1'b0, E_DECODE);
        step2("rst_memadr", 6'b100011, 1'b0, E_MEMADR);
        step2("rst_memrd0", 6'b100011, 1'b0, E_MEMACC);
        step2("rst_memrd1", 6'b100011, 1'b0, E_MEMACC);
        async_reset("memrd_reset");
        step2("post_reset_fetch", 6'b100011, 1'b0, E_FETCH_WAIT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic [18:0] E_MEMWR_WAIT_F();
        return E_MEMACC;
    endfunction

endmodule
